hazard_stall_ctrl: RTL and testbench
====================================

Name: hazard_stall_ctrl

Overview:
- Next-generation pipeline stall controller for the MIPS core.
- Replaces per-cycle combinational stall flags with an internal register scoreboard, per-register forwarding-readiness countdowns and a mult/div busy counter.
- Generates stall_id, stall_ex and stall_rf.
- Sits beside decode/register-file; fed by decode (issue info) and writeback.

Parameters:
- NUM_REGS, 32, architectural registers; register 0 is never tracked.
- REG_ADDR_W, 5, register address width.
- NUM_SRC, 2, source operands checked per issued instruction.
- LAT_W, 3, width of result-latency field and per-register countdown.
- OUT_W, 2, width of per-register outstanding-write counter.
- MD_LATENCY, 32, mult/div busy cycles after an accepted start.
- FWD_EN, 1, 1 = forwarding network present; 0 = stall until writeback.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_issue  in  1  valid instruction in decode.
- id_src_valid  in  NUM_SRC  per-source read enable.
- id_src_addr  in  NUM_SRC*REG_ADDR_W  source addresses, source 0 in LSBs.
- id_dst_we  in  1  instruction writes a GPR.
- id_dst_addr  in  REG_ADDR_W  destination register.
- id_dst_lat  in  LAT_W  cycles until result is forwardable (0 = next cycle).
- id_md_start  in  1  instruction starts mult/div.
- id_md_read  in  1  instruction reads HI/LO.
- wb_we  in  1  writeback retires a GPR write.
- wb_addr  in  REG_ADDR_W  writeback register.
- wb_conflict  in  1  two results target the single writeback port this cycle.
- flush  in  1  kill decode instruction.
- stall_id  out  1  hold fetch/decode.
- stall_ex  out  1  hold execute.
- stall_rf  out  1  hold register-file write stage.
- md_busy  out  1  mult/div counter nonzero.
- stall_count  out  32  saturating count of stall_id cycles.

Behaviour:
- Reset, asynchronous:
  - All outstanding counters, countdowns and the md counter go to 0; stall_count = 0.
  - With inputs idle, all stall outputs are 0.
- Mult/div stall:
  - md_stall = md_busy & id_issue & (id_md_start | id_md_read).
  - The md counter loads MD_LATENCY on an accepted md_start.
  - Otherwise it decrements while nonzero.
- Register stall: for each source i with valid, addr != 0 and out[addr] != 0:
  - With FWD_EN = 1, stall if cnt[addr] != 0.
  - With FWD_EN = 0, stall always.
  - Also stall if id_dst_we and out[id_dst_addr] is saturated (all ones).
  - reg_stall is qualified by id_issue.
- Outputs (combinational, no latency):
  - stall_ex = md_stall.
  - stall_rf = md_stall | wb_conflict.
  - stall_id = md_stall | reg_stall | wb_conflict.
- Accept: accept = id_issue & ~stall_id & ~flush. On accept with id_dst_we and id_dst_addr != 0:
  - out[dst] increments.
  - cnt[dst] loads id_dst_lat; the newest producer wins.
- Countdowns:
  - Every nonzero cnt decrements by 1 per cycle when stall_ex = 0.
  - All countdowns freeze while stall_ex = 1.
- Writeback:
  - wb_we with wb_addr != 0 decrements out[wb_addr].
  - When out reaches 0, cnt is forced to 0.
  - If accept to the same register occurs in the same cycle, out is unchanged (+1 - 1) and cnt loads the new latency.
- Writeback forwarding: a register retiring via wb in the current cycle with out = 1 is treated as ready (no stall) that cycle.
- Register 0:
  - Writes to it are ignored.
  - Reads of it never stall.
- flush: suppresses accept only; in-flight scoreboard state is untouched.
- stall_count: increments each cycle stall_id = 1; saturates at 0xFFFFFFFF.
- Error case: wb_we to a register with out = 0 is ignored (no underflow).

Decomposition:
- Package hazard_pkg holds:
  - Default widths and the MD_LATENCY default.
  - A latency-class constant set: LAT_ALU = 0, LAT_LOAD = 1.
- Sub-module scoreboard_entry, instantiated NUM_REGS-1 times:
  - Holds the out counter and cnt countdown.
  - Inputs: set, clear, freeze, lat.
  - Outputs: pending, ready.
- The md counter and stall muxing stay in the top level.

Test Plan:
- ALU dependence: issue dst r3 lat 0; next cycle issue src r3 -> stall_id = 0 (forwarded).
- Load-use: issue dst r5 lat 1; next cycle src r5 -> stall_id = 1 for exactly 1 cycle, then 0.
- FWD_EN = 0 variant: issue dst r7, wb r7 three cycles later -> consumer stalls until the wb cycle, released that cycle.
- Mult/div: accepted md_start, then id_md_read issued -> stall_id = stall_ex = stall_rf = 1 for MD_LATENCY cycles; md_busy drops after 32 cycles.
- Overlapping writes: two producers r9 back to back, then wb r9 once -> consumer of r9 still stalls (out = 1) until the second wb; same-cycle wb r9 plus issue dst r9 keeps out unchanged.
- Reset and saturation:
  - Assert rst_n = 0 mid-countdown -> all outputs 0 immediately, stall_count = 0.
  - Hold stall_id with stall_count preset near max -> saturates at 0xFFFFFFFF.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared widths, defaults and latency classes for the hazard/stall controller.
package hazard_pkg;

    localparam int NUM_REGS_DEF   = 32;
    localparam int REG_ADDR_W_DEF = 5;
    localparam int NUM_SRC_DEF    = 2;
    localparam int LAT_W_DEF      = 3;
    localparam int OUT_W_DEF      = 2;
    localparam int MD_LATENCY_DEF = 32;

    // Producer latency classes as seen by decode
    localparam logic [LAT_W_DEF-1:0] LAT_ALU  = 3'd0;
    localparam logic [LAT_W_DEF-1:0] LAT_LOAD = 3'd1;

endpackage

// File: rtl/hazard_stall_ctrl_scoreboard_entry.sv
// One scoreboard slot: outstanding-write counter plus forwarding-readiness countdown.
import hazard_pkg::*;

module scoreboard_entry #(
    parameter int LAT_W  = LAT_W_DEF,
    parameter int OUT_W  = OUT_W_DEF,
    parameter bit FWD_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_i,
    input  logic             clear_i,
    input  logic             freeze_i,
    input  logic [LAT_W-1:0] lat_i,
    output logic             pending_o,
    output logic             ready_o,
    output logic             full_o
);

    logic [OUT_W-1:0] out_q, out_d;
    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic             retire_s;
    logic             last_s;

    // A retire against an empty slot is dropped so the counter never underflows
    assign retire_s = clear_i & (out_q != '0);
    assign last_s   = retire_s & (out_q == OUT_W'(1));

    // Next-state for the outstanding counter and countdown
    always_comb begin
        out_d = out_q;
        cnt_d = cnt_q;
        if (set_i && !retire_s) begin
            out_d = out_q + OUT_W'(1);
        end else if (!set_i && retire_s) begin
            out_d = out_q - OUT_W'(1);
        end else begin
            out_d = out_q;
        end
        if (set_i) begin
            cnt_d = lat_i;
        end else if (last_s) begin
            cnt_d = '0;
        end else if (!freeze_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - LAT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Slot state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            cnt_q <= '0;
        end else begin
            out_q <= out_d;
            cnt_q <= cnt_d;
        end
    end

    // Ready qualifies a pending slot; the retiring last writer is forwarded from writeback
    assign pending_o = (out_q != '0);
    assign ready_o   = last_s | (FWD_EN && (cnt_q == '0));
    assign full_o    = (out_q == '1);

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline stall controller: register scoreboard, mult/div busy counter and stall muxing.
import hazard_pkg::*;

module hazard_stall_ctrl #(
    parameter int          NUM_REGS       = NUM_REGS_DEF,
    parameter int          REG_ADDR_W     = REG_ADDR_W_DEF,
    parameter int          NUM_SRC        = NUM_SRC_DEF,
    parameter int          LAT_W          = LAT_W_DEF,
    parameter int          OUT_W          = OUT_W_DEF,
    parameter int          MD_LATENCY     = MD_LATENCY_DEF,
    parameter bit          FWD_EN         = 1'b1,
    parameter logic [31:0] STALL_CNT_INIT = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          id_issue_i,
    input  logic [NUM_SRC-1:0]            id_src_valid_i,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr_i,
    input  logic                          id_dst_we_i,
    input  logic [REG_ADDR_W-1:0]         id_dst_addr_i,
    input  logic [LAT_W-1:0]              id_dst_lat_i,
    input  logic                          id_md_start_i,
    input  logic                          id_md_read_i,
    input  logic                          wb_we_i,
    input  logic [REG_ADDR_W-1:0]         wb_addr_i,
    input  logic                          wb_conflict_i,
    input  logic                          flush_i,
    output logic                          stall_id_o,
    output logic                          stall_ex_o,
    output logic                          stall_rf_o,
    output logic                          md_busy_o,
    output logic [31:0]                   stall_count_o
);

    localparam int MD_W = $clog2(MD_LATENCY + 1);

    logic [NUM_REGS-1:0] pending_s, ready_s, full_s, blocked_s;
    logic [MD_W-1:0]     md_q, md_d;
    logic [31:0]         stall_cnt_q, stall_cnt_d;
    logic                md_stall_s, reg_stall_s, src_hit_s, accept_s;

    // Register 0 is hardwired: never pending, so reads of it never stall
    assign pending_s[0] = 1'b0;
    assign ready_s[0]   = 1'b1;
    assign full_s[0]    = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
        logic set_s, clear_s;
        assign set_s   = accept_s & id_dst_we_i & (id_dst_addr_i == REG_ADDR_W'(r));
        assign clear_s = wb_we_i & (wb_addr_i == REG_ADDR_W'(r));
        scoreboard_entry #(
            .LAT_W  (LAT_W),
            .OUT_W  (OUT_W),
            .FWD_EN (FWD_EN)
        ) u_entry (
            .clk       (clk),
            .rst_n     (rst_n),
            .set_i     (set_s),
            .clear_i   (clear_s),
            .freeze_i  (stall_ex_o),
            .lat_i     (id_dst_lat_i),
            .pending_o (pending_s[r]),
            .ready_o   (ready_s[r]),
            .full_o    (full_s[r])
        );
    end

    assign blocked_s = pending_s & ~ready_s;

    // Any enabled source operand waiting on an unready producer
    always_comb begin
        src_hit_s = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (id_src_valid_i[i] && blocked_s[id_src_addr_i[i*REG_ADDR_W +: REG_ADDR_W]]) begin
                src_hit_s = 1'b1;
            end else begin
                src_hit_s = src_hit_s;
            end
        end
    end

    assign reg_stall_s = id_issue_i & (src_hit_s | (id_dst_we_i & full_s[id_dst_addr_i]));
    assign md_busy_o   = (md_q != '0);
    assign md_stall_s  = md_busy_o & id_issue_i & (id_md_start_i | id_md_read_i);
    assign stall_ex_o  = md_stall_s;
    assign stall_rf_o  = md_stall_s | wb_conflict_i;
    assign stall_id_o  = md_stall_s | reg_stall_s | wb_conflict_i;
    assign accept_s    = id_issue_i & ~stall_id_o & ~flush_i;

    // Mult/div busy counter and saturating stall statistics
    always_comb begin
        md_d        = md_q;
        stall_cnt_d = stall_cnt_q;
        if (accept_s && id_md_start_i) begin
            md_d = MD_W'(MD_LATENCY);
        end else if (md_q != '0) begin
            md_d = md_q - MD_W'(1);
        end else begin
            md_d = md_q;
        end
        if (stall_id_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Top-level state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_q        <= '0;
            stall_cnt_q <= STALL_CNT_INIT;
        end else begin
            md_q        <= md_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench: a forwarding instance (A) and a no-forwarding instance (B) with a near-max stall counter.
module tb_hazard_stall_ctrl;
    import hazard_pkg::*;

    localparam logic [31:0] B_INIT = 32'hFFFF_FFFC;

    typedef struct packed {
        logic       issue;
        logic [1:0] src_valid;
        logic [9:0] src_addr;
        logic       dst_we;
        logic [4:0] dst_addr;
        logic [2:0] dst_lat;
        logic       md_start;
        logic       md_read;
        logic       wb_we;
        logic [4:0] wb_addr;
        logic       wb_conflict;
        logic       flush;
    } drv_t;

    typedef struct {
        string       tag;
        bit          sel;
        logic [3:0]  flags;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    drv_t        ia = '0;
    drv_t        ib = '0;
    logic        a_sid, a_sex, a_srf, a_mdb, b_sid, b_sex, b_srf, b_mdb;
    logic [31:0] a_cnt, b_cnt;
    logic [31:0] exp_cnt [2];
    exp_t        sb [$];
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl u_dut_a (
        .clk(clk), .rst_n(rst_n), .id_issue_i(ia.issue), .id_src_valid_i(ia.src_valid),
        .id_src_addr_i(ia.src_addr), .id_dst_we_i(ia.dst_we), .id_dst_addr_i(ia.dst_addr),
        .id_dst_lat_i(ia.dst_lat), .id_md_start_i(ia.md_start), .id_md_read_i(ia.md_read),
        .wb_we_i(ia.wb_we), .wb_addr_i(ia.wb_addr), .wb_conflict_i(ia.wb_conflict),
        .flush_i(ia.flush), .stall_id_o(a_sid), .stall_ex_o(a_sex), .stall_rf_o(a_srf),
        .md_busy_o(a_mdb), .stall_count_o(a_cnt)
    );

    hazard_stall_ctrl #(.FWD_EN(1'b0), .STALL_CNT_INIT(B_INIT)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .id_issue_i(ib.issue), .id_src_valid_i(ib.src_valid),
        .id_src_addr_i(ib.src_addr), .id_dst_we_i(ib.dst_we), .id_dst_addr_i(ib.dst_addr),
        .id_dst_lat_i(ib.dst_lat), .id_md_start_i(ib.md_start), .id_md_read_i(ib.md_read),
        .wb_we_i(ib.wb_we), .wb_addr_i(ib.wb_addr), .wb_conflict_i(ib.wb_conflict),
        .flush_i(ib.flush), .stall_id_o(b_sid), .stall_ex_o(b_sex), .stall_rf_o(b_srf),
        .md_busy_o(b_mdb), .stall_count_o(b_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic drv_t prod(input logic [4:0] d, input logic [2:0] lat);
        drv_t v = '0;
        v.issue = 1'b1; v.dst_we = 1'b1; v.dst_addr = d; v.dst_lat = lat;
        return v;
    endfunction

    function automatic drv_t cons(input logic [4:0] s, input int slot);
        drv_t v = '0;
        v.issue = 1'b1;
        if (slot == 1) begin v.src_valid = 2'b10; v.src_addr = {s, 5'd0}; end
        else begin v.src_valid = 2'b01; v.src_addr = {5'd0, s}; end
        return v;
    endfunction

    function automatic drv_t wbk(input drv_t base, input logic [4:0] w);
        drv_t v = base;
        v.wb_we = 1'b1; v.wb_addr = w;
        return v;
    endfunction

    // Drive one cycle, push the expectation, then pop and compare mid-cycle.
    // flags = {stall_id, stall_ex, stall_rf, md_busy}
    task automatic cyc(input string tag, input bit sel, input drv_t d, input logic [3:0] flags);
        exp_t e;
        logic [3:0]  obs_f;
        logic [31:0] obs_c;
        @(negedge clk);
        if (sel) begin ib = d; ia = '0; end else begin ia = d; ib = '0; end
        sb.push_back('{tag, sel, flags, exp_cnt[sel]});
        if (flags[3] && (exp_cnt[sel] != 32'hFFFF_FFFF)) exp_cnt[sel] = exp_cnt[sel] + 32'd1;
        #2;
        e = sb.pop_front();
        obs_f = e.sel ? {b_sid, b_sex, b_srf, b_mdb} : {a_sid, a_sex, a_srf, a_mdb};
        obs_c = e.sel ? b_cnt : a_cnt;
        check_eq({e.tag, "_flags"}, 32'(obs_f), 32'(e.flags));
        check_eq({e.tag, "_count"}, obs_c, e.cnt);
    endtask

    initial begin
        drv_t d;
        exp_cnt[0] = 32'd0;
        exp_cnt[1] = B_INIT;
        cyc("reset_a", 1'b0, '0, 4'b0000);
        cyc("reset_b", 1'b1, '0, 4'b0000);
        rst_n = 1'b1;

        cyc("alu_prod", 1'b0, prod(5'd3, LAT_ALU), 4'b0000);
        cyc("alu_cons", 1'b0, cons(5'd3, 0), 4'b0000);
        cyc("alu_wb",   1'b0, wbk('0, 5'd3), 4'b0000);

        cyc("ld_prod",  1'b0, prod(5'd5, LAT_LOAD), 4'b0000);
        cyc("ld_use1",  1'b0, cons(5'd5, 1), 4'b1000);
        cyc("ld_use2",  1'b0, cons(5'd5, 0), 4'b0000);
        cyc("ld_wb",    1'b0, wbk('0, 5'd5), 4'b0000);

        d = prod(5'd6, 3'd5); d.flush = 1'b1;
        cyc("fl_prod",  1'b0, d, 4'b0000);
        cyc("fl_cons",  1'b0, cons(5'd6, 0), 4'b0000);

        cyc("ov_p1",    1'b0, prod(5'd9, 3'd0), 4'b0000);
        cyc("ov_p2",    1'b0, prod(5'd9, 3'd7), 4'b0000);
        cyc("ov_wb1",   1'b0, wbk(cons(5'd9, 0), 5'd9), 4'b1000);
        cyc("ov_wb2",   1'b0, wbk(cons(5'd9, 0), 5'd9), 4'b0000);
        cyc("ov_done",  1'b0, cons(5'd9, 0), 4'b0000);
        cyc("sc_p",     1'b0, prod(5'd9, 3'd3), 4'b0000);
        cyc("sc_wbp",   1'b0, wbk(prod(5'd9, 3'd2), 5'd9), 4'b0000);
        cyc("sc_c1",    1'b0, cons(5'd9, 0), 4'b1000);
        cyc("sc_c2",    1'b0, cons(5'd9, 0), 4'b1000);
        cyc("sc_c3",    1'b0, cons(5'd9, 0), 4'b0000);
        cyc("sc_wb",    1'b0, wbk('0, 5'd9), 4'b0000);

        cyc("r0_prod",  1'b0, prod(5'd0, 3'd7), 4'b0000);
        cyc("r0_cons",  1'b0, cons(5'd0, 0), 4'b0000);

        for (int k = 0; k < 3; k++) cyc("sat_p", 1'b0, prod(5'd4, 3'd5), 4'b0000);
        cyc("sat_full", 1'b0, prod(5'd4, 3'd5), 4'b1000);
        cyc("sat_wbf",  1'b0, wbk(prod(5'd4, 3'd5), 5'd4), 4'b1000);
        cyc("sat_wb2",  1'b0, wbk('0, 5'd4), 4'b0000);
        cyc("sat_wb3",  1'b0, wbk('0, 5'd4), 4'b0000);
        cyc("sat_cons", 1'b0, cons(5'd4, 0), 4'b0000);

        cyc("uf_wb",    1'b0, wbk('0, 5'd10), 4'b0000);
        cyc("uf_prod",  1'b0, prod(5'd10, 3'd4), 4'b0000);
        cyc("uf_cons",  1'b0, cons(5'd10, 0), 4'b1000);
        cyc("uf_clr",   1'b0, wbk('0, 5'd10), 4'b0000);

        d = prod(5'd13, 3'd5); d.wb_conflict = 1'b1;
        cyc("wc_prod",  1'b0, d, 4'b1010);
        cyc("wc_cons",  1'b0, cons(5'd13, 0), 4'b0000);

        d = prod(5'd11, 3'd2); d.md_start = 1'b1;
        cyc("md_start", 1'b0, d, 4'b0000);
        d = '0; d.issue = 1'b1; d.md_read = 1'b1;
        for (int k = 0; k < MD_LATENCY_DEF; k++) cyc("md_wait", 1'b0, d, 4'b1111);
        cyc("md_free",  1'b0, d, 4'b0000);
        cyc("md_frz1",  1'b0, cons(5'd11, 0), 4'b1000);
        cyc("md_frz2",  1'b0, cons(5'd11, 0), 4'b0000);
        cyc("md_clr",   1'b0, wbk('0, 5'd11), 4'b0000);

        cyc("b_prod",   1'b1, prod(5'd7, LAT_ALU), 4'b0000);
        cyc("b_cons1",  1'b1, cons(5'd7, 0), 4'b1000);
        cyc("b_cons2",  1'b1, cons(5'd7, 0), 4'b1000);
        cyc("b_wbrel",  1'b1, wbk(cons(5'd7, 0), 5'd7), 4'b0000);
        d = '0; d.wb_conflict = 1'b1;
        cyc("b_conf1",  1'b1, d, 4'b1010);
        cyc("b_conf2",  1'b1, d, 4'b1010);
        cyc("b_idle",   1'b1, '0, 4'b0000);

        cyc("rst_prod", 1'b0, prod(5'd12, 3'd7), 4'b0000);
        @(negedge clk);
        ia = cons(5'd12, 0);
        #1;
        check_eq("rst_pre_stall", 32'(a_sid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_now_flags", 32'({a_sid, a_sex, a_srf, a_mdb}), 32'd0);
        check_eq("rst_now_count", a_cnt, 32'd0);
        check_eq("rst_now_count_b", b_cnt, B_INIT);
        rst_n = 1'b1;
        exp_cnt[0] = 32'd0;
        exp_cnt[1] = B_INIT;
        cyc("rst_post", 1'b0, cons(5'd12, 0), 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
